// File: rtl/tpg_source.sv
// Traffic pattern generator: emits src|dst|id|seq packets over valid/ready.
// All outputs are registered; the FSM computes next-cycle values combinationally.
module tpg_source #(
  parameter int WIDTH        = 32,
  parameter int N            = 16,
  parameter int N_ADDR_WIDTH = $clog2(N),
  parameter int NODE         = 0,
  parameter int DEST         = 15,
  parameter int NUM_PACKETS  = 100,
  parameter int GAP          = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  input  logic             ready_in,
  output logic             done,
  output logic [31:0]      sent_count
);

  localparam int A  = N_ADDR_WIDTH;
  localparam int DW = WIDTH - 2*A - 8;
  // Gap counter needs at least one bit even when GAP is 0 (WAIT unreachable then).
  localparam int GW = (GAP < 1) ? 1 : $clog2(GAP + 1);

  if (DW < 1) begin : g_bad_width
    $error("tpg_source: WIDTH too small for src/dst/id fields (DW < 1)");
  end

  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

  state_t           state, state_n;
  logic [7:0]       id, id_n;
  logic [DW-1:0]    seq, seq_n;
  logic [GW-1:0]    gap_cnt, gap_n;
  logic [WIDTH-1:0] data_n;
  logic             valid_n, done_n;
  logic [31:0]      cnt_n;

  function automatic logic [WIDTH-1:0] pack(input logic [7:0] pid, input logic [DW-1:0] pseq);
    return {A'(NODE), A'(DEST), pid, pseq};
  endfunction

  // Next-state and next-output logic; a presented packet is only left on transfer.
  always_comb begin
    state_n = state;
    valid_n = valid_out;
    data_n  = data_out;
    done_n  = done;
    cnt_n   = sent_count;
    id_n    = id;
    seq_n   = seq;
    gap_n   = gap_cnt;
    case (state)
      IDLE: begin
        valid_n = 1'b0;
        if (enable) begin
          data_n  = pack(id, seq);
          valid_n = 1'b1;
          state_n = SEND;
        end
      end
      SEND: begin
        if (valid_out && ready_in) begin
          id_n    = id + 8'd1;
          seq_n   = seq + DW'(1);
          cnt_n   = (sent_count == 32'hFFFF_FFFF) ? sent_count : sent_count + 32'd1;
          valid_n = 1'b0;
          if (NUM_PACKETS != 0 && cnt_n == 32'(NUM_PACKETS)) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else if (GAP > 0) begin
            state_n = WAIT;
            gap_n   = GW'(GAP);
          end else if (enable) begin
            data_n  = pack(id_n, seq_n);
            valid_n = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      WAIT: begin
        valid_n = 1'b0;
        if (gap_cnt <= GW'(1)) begin
          if (enable) begin
            data_n  = pack(id, seq);
            valid_n = 1'b1;
            state_n = SEND;
          end else begin
            state_n = IDLE;
          end
        end else begin
          gap_n = gap_cnt - GW'(1);
        end
      end
      DONE: begin
        valid_n = 1'b0;
        done_n  = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers; reset drops any presented packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      valid_out  <= 1'b0;
      data_out   <= '0;
      done       <= 1'b0;
      sent_count <= '0;
      id         <= '0;
      seq        <= '0;
      gap_cnt    <= '0;
    end else begin
      state      <= state_n;
      valid_out  <= valid_n;
      data_out   <= data_n;
      done       <= done_n;
      sent_count <= cnt_n;
      id         <= id_n;
      seq        <= seq_n;
      gap_cnt    <= gap_n;
    end
  end

endmodule

// File: tb/tb_tpg_source.sv
// Directed bench for tpg_source: three configurations sharing one clock.
module tb_tpg_source;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // a: NUM_PACKETS=3 GAP=0, b: NUM_PACKETS=2 GAP=2, c: unlimited
  logic        rst_a, en_a, rdy_a, vld_a, done_a;
  logic        rst_b, en_b, rdy_b, vld_b, done_b;
  logic        rst_c, en_c, rdy_c, vld_c, done_c;
  logic [31:0] dat_a, dat_b, dat_c, cnt_a, cnt_b, cnt_c;

  tpg_source #(.WIDTH(32), .N(16), .NODE(3), .DEST(15), .NUM_PACKETS(3), .GAP(0)) u_a (
    .clk(clk), .rst(rst_a), .enable(en_a), .data_out(dat_a), .valid_out(vld_a),
    .ready_in(rdy_a), .done(done_a), .sent_count(cnt_a));

  tpg_source #(.WIDTH(32), .N(16), .NODE(3), .DEST(15), .NUM_PACKETS(2), .GAP(2)) u_b (
    .clk(clk), .rst(rst_b), .enable(en_b), .data_out(dat_b), .valid_out(vld_b),
    .ready_in(rdy_b), .done(done_b), .sent_count(cnt_b));

  tpg_source #(.WIDTH(32), .N(16), .NODE(3), .DEST(15), .NUM_PACKETS(0), .GAP(0)) u_c (
    .clk(clk), .rst(rst_c), .enable(en_c), .data_out(dat_c), .valid_out(vld_c),
    .ready_in(rdy_c), .done(done_c), .sent_count(cnt_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // advance one edge, then settle before sampling/driving
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_a = 1; en_a = 0; rdy_a = 0;
    rst_b = 1; en_b = 0; rdy_b = 0;
    rst_c = 1; en_c = 0; rdy_c = 0;
    tick(); tick();

    // reset state
    chk("rst_vld_a", {31'd0, vld_a}, 0);
    chk("rst_dat_a", dat_a, 0);
    chk("rst_done_a", {31'd0, done_a}, 0);
    chk("rst_cnt_a", cnt_a, 0);
    chk("rst_vld_b", {31'd0, vld_b}, 0);
    chk("rst_cnt_c", cnt_c, 0);

    // 1: three back-to-back packets then done
    rst_a = 0; en_a = 1; rdy_a = 1;
    tick();
    chk("t1_vld0", {31'd0, vld_a}, 1);
    chk("t1_dat0", dat_a, 32'h3F00_0000);
    tick();
    chk("t1_vld1", {31'd0, vld_a}, 1);
    chk("t1_dat1", dat_a, 32'h3F01_0001);
    tick();
    chk("t1_dat2", dat_a, 32'h3F02_0002);
    tick();
    chk("t1_vld_end", {31'd0, vld_a}, 0);
    chk("t1_done", {31'd0, done_a}, 1);
    chk("t1_cnt", cnt_a, 3);
    en_a = 1;
    tick();
    chk("t1_done_sticky", {31'd0, done_a}, 1);
    chk("t1_no_restart", {31'd0, vld_a}, 0);

    // 2: backpressure holds the first packet
    rst_a = 1; en_a = 0; rdy_a = 0;
    tick();
    rst_a = 0; en_a = 1;
    tick();
    chk("t2_vld_first", {31'd0, vld_a}, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_hold_vld", {31'd0, vld_a}, 1);
      chk("t2_hold_dat", dat_a, 32'h3F00_0000);
      chk("t2_hold_cnt", cnt_a, 0);
    end
    rdy_a = 1;
    tick();
    chk("t2_cnt", cnt_a, 1);
    chk("t2_next_dat", dat_a, 32'h3F01_0001);

    // 5: enable drop cannot withdraw a presented packet; resume continues id/seq
    rdy_a = 0; en_a = 0;
    tick();
    chk("t5_hold_vld", {31'd0, vld_a}, 1);
    chk("t5_hold_dat", dat_a, 32'h3F01_0001);
    rdy_a = 1;
    tick();
    chk("t5_idle_vld", {31'd0, vld_a}, 0);
    chk("t5_cnt", cnt_a, 2);
    tick();
    chk("t5_idle_stay", {31'd0, vld_a}, 0);
    en_a = 1;
    tick();
    chk("t5_resume_vld", {31'd0, vld_a}, 1);
    chk("t5_resume_dat", dat_a, 32'h3F02_0002);
    tick();
    chk("t5_done", {31'd0, done_a}, 1);
    chk("t5_cnt_end", cnt_a, 3);

    // 6: reset while a packet is being offered with ready high
    rst_a = 1; en_a = 0;
    tick();
    rst_a = 0; en_a = 1; rdy_a = 1;
    tick();
    chk("t6_vld", {31'd0, vld_a}, 1);
    rst_a = 1;
    tick();
    chk("t6_rst_vld", {31'd0, vld_a}, 0);
    chk("t6_rst_cnt", cnt_a, 0);
    chk("t6_rst_done", {31'd0, done_a}, 0);
    rst_a = 0;
    tick();
    chk("t6_restart_dat", dat_a, 32'h3F00_0000);
    chk("t6_restart_vld", {31'd0, vld_a}, 1);
    tick();
    chk("t6_restart_cnt", cnt_a, 1);

    // 3: GAP=2 gives valid pattern 1,0,0,1,0
    rst_b = 0; en_b = 1; rdy_b = 1;
    tick();
    chk("t3_p0", {31'd0, vld_b}, 1);
    chk("t3_dat0", dat_b, 32'h3F00_0000);
    tick();
    chk("t3_p1", {31'd0, vld_b}, 0);
    tick();
    chk("t3_p2", {31'd0, vld_b}, 0);
    tick();
    chk("t3_p3", {31'd0, vld_b}, 1);
    chk("t3_dat1", dat_b, 32'h3F01_0001);
    tick();
    chk("t3_p4", {31'd0, vld_b}, 0);
    chk("t3_done", {31'd0, done_b}, 1);
    chk("t3_cnt", cnt_b, 2);

    // 4: unlimited run past id wrap
    rst_c = 0; en_c = 1; rdy_c = 1;
    for (int i = 0; i < 257; i++) begin
      tick();
      if (i == 255) chk("t4_idx255", dat_c, 32'h3FFF_00FF);
    end
    chk("t4_idx256", dat_c, 32'h3F00_0100);
    chk("t4_cnt256", cnt_c, 256);
    tick();
    chk("t4_cnt257", cnt_c, 257);
    chk("t4_done", {31'd0, done_c}, 0);
    chk("t4_vld", {31'd0, vld_c}, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tpg_source.md
Name: tpg_source

Overview:
- Synthesizable traffic pattern generator. Sits directly upstream of a NoC node's traffic sink, or drives a router input port.
- Emits a programmable number of packets to a fixed destination over a valid/ready stream.
- Packet layout, MSB to LSB: src | dst | id | data sequence.
- Lets the sink's RECV log be checked against known src, dst, id and data values.

Parameters:
- WIDTH, 32, packet width in bits.
- N, 16, number of NoC nodes.
- N_ADDR_WIDTH, $clog2(N), node address field width (A).
- NODE, 0, source address inserted in every packet. Width A.
- DEST, 15, destination address inserted in every packet. Width A.
- NUM_PACKETS, 100, packets to send before done. 0 means unlimited.
- GAP, 0, idle cycles (valid_out low) inserted after each accepted packet.

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset: synchronous, active-high.
- enable, input, 1, level; start/continue generation.
- data_out, output, WIDTH, packet.
- valid_out, output, 1, data_out holds a packet.
- ready_in, input, 1, downstream accepts.
- done, output, 1, sticky; NUM_PACKETS transferred.
- sent_count, output, 32, packets transferred so far.

Behaviour:
- Field layout:
  - data_out[WIDTH-1 -: A] = NODE.
  - data_out[WIDTH-1-A -: A] = DEST.
  - data_out[WIDTH-1-2A -: 8] = id.
  - data_out[DW-1:0] = seq, where DW = WIDTH-2A-8. Elaboration error if DW < 1.
- id is an 8-bit counter that wraps 255->0. seq is a DW-bit counter that wraps modulo 2^DW. Both start at 0 and increment by 1 on each transfer.
- Transfer occurs on a clk edge with valid_out && ready_in.
- Handshake rules:
  - Once valid_out rises, it and data_out stay stable until the transfer.
  - Neither enable nor ready_in may withdraw a presented packet.
  - valid_out never depends combinationally on ready_in.
- All outputs are registered. Reset values: valid_out=0, data_out=0, done=0, sent_count=0, id=0, seq=0, state=IDLE.
- FSM state IDLE:
  - valid_out=0.
  - If enable and not finished: load the packet, set valid_out=1 next cycle, go to SEND. Latency is 1 cycle from enable sampled high.
- FSM state SEND:
  - valid_out=1. Hold while ready_in=0.
  - On transfer, sent_count++, id++ and seq++.
  - If NUM_PACKETS!=0 and new sent_count==NUM_PACKETS: go to DONE, valid_out=0, done=1 next cycle.
  - Else if GAP>0: go to WAIT, valid_out=0, gap counter=GAP.
  - Else if enable: stay in SEND with the next packet presented the next cycle. This gives back-to-back, 1 packet/cycle throughput.
  - Else: go to IDLE, valid_out=0.
- FSM state WAIT:
  - valid_out=0. Gap counter decrements each cycle.
  - When it reaches 1: if enable go to SEND (valid_out=1 next cycle), else go to IDLE.
  - Exactly GAP low cycles between the transfer edge and the next valid_out high.
- FSM state DONE:
  - valid_out=0, done=1. Terminal until rst; enable is ignored.
- Pause and resume: counters are preserved across IDLE. Resume continues with the next id/seq, with no repeats or skips.
- rst mid-packet (valid_out=1, not accepted): the packet is dropped. Next edge gives valid_out=0 and all counters 0. No transfer is counted on the rst edge even if ready_in=1.
- sent_count saturates at 2^32-1.
- NUM_PACKETS=0: done never asserts; generation runs while enable is high.

Test Plan:
Config for all scenarios: WIDTH=32, N=16 (A=4, DW=16), NODE=3, DEST=15.
1. NUM_PACKETS=3, GAP=0, ready_in=1, enable high from cycle 0.
   - valid_out high cycles 1-3.
   - data_out = 0x3F000000, 0x3F010001, 0x3F020002.
   - valid_out low and done=1 at cycle 4; sent_count=3.
2. Backpressure: ready_in=0 for 5 cycles after the first valid.
   - data_out holds 0x3F000000 and valid_out stays 1 throughout.
   - Packet accepted on the first ready edge; sent_count goes to 1.
3. GAP=2, NUM_PACKETS=2, ready_in=1.
   - valid_out pattern 1,0,0,1,0.
   - Second packet is 0x3F010001; done rises after it.
4. NUM_PACKETS=0, 257 transfers.
   - Packet index 256 = 0x3F000100 (id wrapped to 0, seq=256).
   - done stays 0; sent_count=257.
5. Drop enable while valid_out=1 and ready_in=0, then raise ready_in.
   - Packet completes; FSM goes to IDLE with valid_out=0.
   - Re-enable: next packet carries id/seq one greater than the last.
6. Assert rst for 1 cycle while valid_out=1 and ready_in=1.
   - No count increment; next cycle valid_out=0, sent_count=0.
   - After re-enable, first packet is 0x3F000000.
